// File: rtl/fft_sequencer.sv
// Frame controller for the FFT core: loads N samples, starts the core, waits for done
// under a watchdog, then streams the result and reports the largest |re|+|im| bin.
module fft_sequencer #(
  parameter int unsigned N       = 512,
  parameter int unsigned AW      = 9,
  parameter int unsigned DW      = 16,
  parameter int unsigned OUT_LAT = 1,
  parameter int unsigned MIN_BIN = 1,
  parameter int unsigned MAX_BIN = 255,
  parameter int unsigned BITREV  = 0,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            sample_valid,
  input  logic [DW-1:0]   sample_data,
  input  logic            fft_done,
  input  logic [2*DW-1:0] fft_data,
  output logic            fft_reset,
  output logic            fft_load,
  output logic [AW-1:0]   fft_load_address,
  output logic [2*DW-1:0] fft_data_in,
  output logic            fft_start,
  output logic            busy,
  output logic            sample_dropped,
  output logic            result_valid,
  output logic [AW-1:0]   peak_bin,
  output logic [DW:0]     peak_mag,
  output logic            timeout_err
);

  localparam int unsigned RW = $clog2(OUT_LAT + N + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] RD_FIRST  = RW'(OUT_LAT);
  localparam logic [RW-1:0] RD_LAST   = RW'(OUT_LAT + N - 1);
  localparam logic [AW-1:0] LD_LAST   = AW'(N - 1);
  localparam logic [AW-1:0] MIN_K     = AW'(MIN_BIN);
  localparam logic [AW-1:0] MAX_K     = AW'(MAX_BIN);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_READ, S_REPORT} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ld_cnt_q, ld_cnt_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [RW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [DW:0]       run_mag_q, run_mag_d;
  logic [AW-1:0]     run_bin_q, run_bin_d;
  logic              fft_reset_q, fft_reset_d;
  logic              fft_load_q, fft_load_d;
  logic [AW-1:0]     load_addr_q, load_addr_d;
  logic [2*DW-1:0]   data_in_q, data_in_d;
  logic              fft_start_q, fft_start_d;
  logic              busy_q, busy_d;
  logic              dropped_q, dropped_d;
  logic              result_valid_q, result_valid_d;
  logic [AW-1:0]     peak_bin_q, peak_bin_d;
  logic [DW:0]       peak_mag_q, peak_mag_d;
  logic              timeout_err_q, timeout_err_d;

  logic [AW-1:0]     k_lin, k_rev, k_bin;
  logic [DW:0]       re_x, im_x, abs_re, abs_im, mag;
  logic              in_window;

  // Candidate bin and magnitude of the word currently on fft_data.
  always_comb begin
    k_lin = AW'(rd_cnt_q - RD_FIRST);
    k_rev = '0;
    for (int unsigned i = 0; i < AW; i++) k_rev[i] = k_lin[AW-1-i];
    k_bin     = (BITREV != 0) ? k_rev : k_lin;
    re_x      = {fft_data[2*DW-1], fft_data[2*DW-1:DW]};
    im_x      = {fft_data[DW-1], fft_data[DW-1:0]};
    abs_re    = re_x[DW] ? (~re_x + (DW+1)'(1)) : re_x;
    abs_im    = im_x[DW] ? (~im_x + (DW+1)'(1)) : im_x;
    mag       = abs_re + abs_im;
    in_window = (rd_cnt_q >= RD_FIRST) && (rd_cnt_q <= RD_LAST) &&
                (k_bin >= MIN_K) && (k_bin <= MAX_K);
  end

  always_comb begin
    state_d        = state_q;
    ld_cnt_d       = ld_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    run_mag_d      = run_mag_q;
    run_bin_d      = run_bin_q;
    fft_load_d     = 1'b0;
    load_addr_d    = load_addr_q;
    data_in_d      = data_in_q;
    fft_start_d    = 1'b0;
    dropped_d      = sample_valid && (state_q != S_LOAD);
    result_valid_d = 1'b0;
    peak_bin_d     = peak_bin_q;
    peak_mag_d     = peak_mag_q;
    timeout_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ld_cnt_d   = '0;
        wait_cnt_d = '0;
        rd_cnt_d   = '0;
        run_mag_d  = '0;
        run_bin_d  = MIN_K;
        if (enable) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (sample_valid) begin
          fft_load_d  = 1'b1;
          load_addr_d = ld_cnt_q;
          data_in_d   = {sample_data, DW'(0)};
          ld_cnt_d    = ld_cnt_q + AW'(1);
          if (ld_cnt_q == LD_LAST) state_d = S_START;
        end
      end
      S_START: begin
        fft_start_d = 1'b1;
        wait_cnt_d  = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (fft_done) begin
          rd_cnt_d = '0;
          state_d  = S_READ;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      S_READ: begin
        rd_cnt_d = rd_cnt_q + RW'(1);
        if (in_window && (mag > run_mag_q)) begin
          run_mag_d = mag;
          run_bin_d = k_bin;
        end
        // The last word is folded in here so the strobe lands in the REPORT cycle.
        if (rd_cnt_q == RD_LAST) begin
          peak_bin_d     = run_bin_d;
          peak_mag_d     = run_mag_d;
          result_valid_d = 1'b1;
          state_d        = S_REPORT;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    fft_reset_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ld_cnt_q       <= '0;
      wait_cnt_q     <= '0;
      rd_cnt_q       <= '0;
      run_mag_q      <= '0;
      run_bin_q      <= MIN_K;
      fft_reset_q    <= 1'b1;
      fft_load_q     <= 1'b0;
      load_addr_q    <= '0;
      data_in_q      <= '0;
      fft_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      dropped_q      <= 1'b0;
      result_valid_q <= 1'b0;
      peak_bin_q     <= '0;
      peak_mag_q     <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      ld_cnt_q       <= ld_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      run_mag_q      <= run_mag_d;
      run_bin_q      <= run_bin_d;
      fft_reset_q    <= fft_reset_d;
      fft_load_q     <= fft_load_d;
      load_addr_q    <= load_addr_d;
      data_in_q      <= data_in_d;
      fft_start_q    <= fft_start_d;
      busy_q         <= busy_d;
      dropped_q      <= dropped_d;
      result_valid_q <= result_valid_d;
      peak_bin_q     <= peak_bin_d;
      peak_mag_q     <= peak_mag_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign fft_reset        = fft_reset_q;
  assign fft_load         = fft_load_q;
  assign fft_load_address = load_addr_q;
  assign fft_data_in      = data_in_q;
  assign fft_start        = fft_start_q;
  assign busy             = busy_q;
  assign sample_dropped   = dropped_q;
  assign result_valid     = result_valid_q;
  assign peak_bin         = peak_bin_q;
  assign peak_mag         = peak_mag_q;
  assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Scoreboard bench for fft_sequencer: the driver pushes expected loads, starts, drops,
// timeouts and peak reports; a negedge monitor pops and compares them as they appear.
module tb_fft_sequencer;

  localparam int N = 512, AW = 9, DW = 16, OUT_LAT = 1;
  localparam int MIN_BIN = 1, MAX_BIN = 255, TIMEOUT = 4096;

  logic          clk = 1'b0;
  logic          reset, enable, sample_valid, fft_done;
  logic [DW-1:0] sample_data;
  logic [31:0]   fft_data;
  logic          fft_reset, fft_load, fft_start, busy, sample_dropped, result_valid, timeout_err;
  logic [AW-1:0] fft_load_address, peak_bin;
  logic [31:0]   fft_data_in;
  logic [DW:0]   peak_mag;

  fft_sequencer #(.N(N), .AW(AW), .DW(DW), .OUT_LAT(OUT_LAT), .MIN_BIN(MIN_BIN),
                  .MAX_BIN(MAX_BIN), .BITREV(0), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .fft_done(fft_done), .fft_data(fft_data),
    .fft_reset(fft_reset), .fft_load(fft_load), .fft_load_address(fft_load_address),
    .fft_data_in(fft_data_in), .fft_start(fft_start), .busy(busy),
    .sample_dropped(sample_dropped), .result_valid(result_valid), .peak_bin(peak_bin),
    .peak_mag(peak_mag), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  typedef struct { int c; logic [AW-1:0] a; logic [31:0] d; } load_t;
  typedef struct { int c; logic [AW-1:0] bin; logic [DW:0] mag; } res_t;
  load_t load_q[$];
  res_t  res_q[$];
  int    start_q[$], drop_q[$], tmo_q[$];
  logic [31:0]   spec [N];
  logic [AW-1:0] hold_bin = '0;
  logic [DW:0]   hold_mag = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  function automatic logic [31:0] w(input int re, input int im);
    logic [15:0] a, b;
    a = 16'(re);
    b = 16'(im);
    return {a, b};
  endfunction

  function automatic int rs(input int n);
    return int'($urandom_range(0, 2 * n)) - n;
  endfunction

  // Reference: scan the window in stream order, keep the first strictly larger |re|+|im|.
  function automatic res_t ref_peak(input int c);
    res_t r;
    int best, bb, re, im, m;
    best = 0;
    bb   = MIN_BIN;
    for (int k = MIN_BIN; k <= MAX_BIN; k++) begin
      re = int'($signed(spec[k][31:16]));
      im = int'($signed(spec[k][15:0]));
      m  = (re < 0 ? -re : re) + (im < 0 ? -im : im);
      if (m > best) begin best = m; bb = k; end
    end
    r.c = c; r.bin = AW'(bb); r.mag = (DW+1)'(best);
    return r;
  endfunction

  task automatic gen_spectrum(input int mode);
    for (int k = 0; k < N; k++)
      case (mode)
        4:       spec[k] = w(rs(8), rs(8));
        5:       spec[k] = $urandom;
        default: spec[k] = 32'h0;
      endcase
    case (mode)
      1: spec[37] = w(-1000, 500);
      2: begin
        spec[0] = w(800, 0);   spec[40]  = w(-300, 500);
        spec[90] = w(400, -400); spec[300] = w(0, -800);
      end
      3: spec[5] = w(-32768, -32768);
      default: ;
    endcase
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_fft_reset"}, fft_reset, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fft_load"}, fft_load, 0);
    check({tag, "_load_addr"}, fft_load_address, 0);
    check({tag, "_data_in"}, fft_data_in, 0);
    check({tag, "_fft_start"}, fft_start, 0);
    check({tag, "_dropped"}, sample_dropped, 0);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_peak_bin"}, peak_bin, 0);
    check({tag, "_peak_mag"}, peak_mag, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  // LOAD becomes visible at cycle l0; returns the first WAIT cycle.
  task automatic load_frame(input int l0, input bit ramp, input bit gaps, input int en_off_at,
                            output int w0);
    load_t le;
    int lc;
    logic [DW-1:0] d;
    wait_until(l0);
    lc = l0;
    for (int i = 0; i < N; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) tick();
      d = ramp ? DW'(i) : DW'($urandom);
      sample_valid = 1'b1;
      sample_data  = d;
      le.c = cyc + 1; le.a = AW'(i); le.d = {d, 16'h0};
      load_q.push_back(le);
      if (i == en_off_at) enable = 1'b0;
      lc = cyc;
      tick();
      sample_valid = 1'b0;
    end
    start_q.push_back(lc + 2);
    w0 = lc + 2;
  endtask

  // Core model: done raised dly cycles into WAIT; bin k is driven when rd_cnt = k+OUT_LAT.
  task automatic read_frame(input int w0, input int dly, input int abort_at, output int dc);
    res_t r;
    dc = w0 + dly;
    wait_until(dc);
    fft_done = 1'b1;
    fft_data = $urandom;
    if (abort_at < 0) begin
      r = ref_peak(dc + OUT_LAT + N + 1);
      res_q.push_back(r);
    end
    tick();
    for (int j = 0; j < OUT_LAT; j++) begin
      fft_data = $urandom;
      tick();
    end
    for (int k = 0; k < N; k++) begin
      fft_data = spec[k];
      if (k == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("abort");
        tick();
        reset = 1'b0;
        break;
      end
      tick();
    end
    fft_done = 1'b0;
    fft_data = $urandom;
  endtask

  task automatic check_gap(input int dc, input bit next_on);
    wait_until(dc + OUT_LAT + N + 2);
    @(negedge clk);
    check("gap_idle_fft_reset", fft_reset, 1);
    check("gap_idle_busy", busy, 0);
    tick();
    @(negedge clk);
    check("gap_next_fft_reset", fft_reset, next_on ? 0 : 1);
    check("gap_next_busy", busy, next_on ? 1 : 0);
  endtask

  always @(negedge clk) begin : monitor
    load_t le;
    res_t  rr;
    int    ec;
    if (fft_load) begin
      if (load_q.size() == 0) check("load_unexpected", 1, 0);
      else begin
        le = load_q.pop_front();
        check("load_cycle", cyc, le.c);
        check("load_addr", fft_load_address, le.a);
        check("load_data", fft_data_in, le.d);
      end
    end
    if (fft_start) begin
      if (start_q.size() == 0) check("start_unexpected", 1, 0);
      else begin ec = start_q.pop_front(); check("start_cycle", cyc, ec); end
    end
    if (sample_dropped) begin
      if (drop_q.size() == 0) check("drop_unexpected", 1, 0);
      else begin ec = drop_q.pop_front(); check("drop_cycle", cyc, ec); end
    end
    if (timeout_err) begin
      if (tmo_q.size() == 0) check("timeout_unexpected", 1, 0);
      else begin ec = tmo_q.pop_front(); check("timeout_cycle", cyc, ec); end
    end
    if (reset) begin hold_bin = '0; hold_mag = '0; end
    if (result_valid) begin
      if (res_q.size() == 0) check("result_unexpected", 1, 0);
      else begin
        rr = res_q.pop_front();
        check("result_cycle", cyc, rr.c);
        check("peak_bin", peak_bin, rr.bin);
        check("peak_mag", peak_mag, rr.mag);
        hold_bin = rr.bin;
        hold_mag = rr.mag;
      end
    end else begin
      check("peak_hold_bin", peak_bin, hold_bin);
      check("peak_hold_mag", peak_mag, hold_mag);
    end
  end

  initial begin : guard
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin : driver
    int w0, dc, l0;
    int modes[7] = '{2, 3, 0, 4, 5, 4, 5};
    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_data = '0;
    fft_done = 1'b0; fft_data = '0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_values("por");
    tick();
    reset = 1'b0;
    tick();
    enable = 1'b1;
    l0 = cyc + 1;

    // Ramp load and single peak at bin 37, done 20 cycles after start.
    load_frame(l0, 1'b1, 1'b0, -1, w0);
    gen_spectrum(1);
    read_frame(w0, 20, -1, dc);
    check_gap(dc, 1'b1);
    l0 = dc + OUT_LAT + N + 3;

    foreach (modes[m]) begin
      load_frame(l0, 1'b0, 1'b1, -1, w0);
      gen_spectrum(modes[m]);
      read_frame(w0, int'($urandom_range(0, 60)), -1, dc);
      check_gap(dc, 1'b1);
      l0 = dc + OUT_LAT + N + 3;
    end

    // Watchdog frame with samples offered during WAIT.
    load_frame(l0, 1'b0, 1'b1, -1, w0);
    wait_until(w0 + 3);
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1;
      sample_data  = DW'($urandom);
      drop_q.push_back(cyc + 1);
      tick();
    end
    sample_valid = 1'b0;
    tmo_q.push_back(w0 + TIMEOUT);
    wait_until(w0 + TIMEOUT);
    @(negedge clk);
    check("timeout_idle_busy", busy, 0);
    check("timeout_idle_fft_reset", fft_reset, 1);
    l0 = w0 + TIMEOUT + 1;

    // Enable dropped mid-load: the frame still completes, then the block stays idle.
    load_frame(l0, 1'b0, 1'b1, 200, w0);
    gen_spectrum(5);
    read_frame(w0, int'($urandom_range(0, 60)), -1, dc);
    check_gap(dc, 1'b0);

    // Reset mid-READ discards the frame.
    repeat (3) tick();
    enable = 1'b1;
    l0 = cyc + 1;
    load_frame(l0, 1'b0, 1'b1, 0, w0);
    gen_spectrum(4);
    read_frame(w0, int'($urandom_range(0, 60)), 100, dc);
    repeat (5) tick();
    @(negedge clk);
    check_reset_values("post_abort");

    repeat (10) tick();
    check("load_q_empty", load_q.size(), 0);
    check("start_q_empty", start_q.size(), 0);
    check("drop_q_empty", drop_q.size(), 0);
    check("timeout_q_empty", tmo_q.size(), 0);
    check("result_q_empty", res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
